ps2_scancode_sequencer: RTL and testbench

Sequences the raw byte stream from the PS/2 keyboard interface into decoded key events for the processor. It sits between `PS2_Interface` (its `ps2_key_data` / `ps2_key_pressed` outputs) and the processor's memory-mapped keyboard port. It tracks the E0 (extended) and F0 (break) prefixes with a small state machine, aborts half-received sequences on timeout, and buffers complete events in a first-word-fall-through FIFO that the processor drains by pulsing `rd_en`.

---
 rtl/ps2_scancode_sequencer_if.sv | 29 ++
 rtl/ps2_scancode_sequencer.sv | 133 +++++++++++++
 tb/tb_ps2_scancode_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_sequencer_if.sv
// rtl/ps2_scancode_sequencer_if.sv - byte input, event output and control bundle for the scancode sequencer
interface ps2_scancode_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          rd_en;
    logic          clr_overflow;
    logic          event_valid;
    logic [9:0]    event_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          seq_error;
    logic          shift_held;

    // Upstream byte source and processor side.
    modport master (
        output byte_valid, byte_data, rd_en, clr_overflow,
        input  event_valid, event_data, fifo_count, overflow, seq_error, shift_held
    );

    // Sequencer side.
    modport slave (
        input  byte_valid, byte_data, rd_en, clr_overflow,
        output event_valid, event_data, fifo_count, overflow, seq_error, shift_held
    );
endinterface

// File: rtl/ps2_scancode_sequencer.sv
// rtl/ps2_scancode_sequencer.sv - PS/2 E0/F0 prefix decoder with timeout and FWFT event FIFO
module ps2_scancode_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input logic                   inclock,
    input logic                   resetn,
    ps2_scancode_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [21:0]   TMO_LAST = 22'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_next;
    logic [21:0]   tmo_cnt;
    logic          timeout;
    logic          emit, proto_err;
    logic [9:0]    emit_data;
    logic          shift_l, shift_r, shift_l_next, shift_r_next;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count_next;
    logic          do_push, do_pop, drop;
    logic [9:0]    head_next;

    // Prefix decode: what the current byte (or a timeout) does to the sequence.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_data  = '0;
        proto_err  = 1'b0;
        timeout    = (state != IDLE) && !bus.byte_valid && (tmo_cnt == TMO_LAST);
        if (bus.byte_valid) begin
            case (state)
                IDLE: begin
                    if (bus.byte_data == 8'hE0)      state_next = EXT;
                    else if (bus.byte_data == 8'hF0) state_next = BRK;
                    else if (bus.byte_data != 8'hAA && bus.byte_data != 8'hFA) begin
                        emit      = 1'b1;
                        emit_data = {2'b00, bus.byte_data};
                    end
                end
                EXT: begin
                    if (bus.byte_data == 8'hF0)      state_next = EXT_BRK;
                    else if (bus.byte_data != 8'hE0) begin
                        emit       = 1'b1;
                        emit_data  = {2'b01, bus.byte_data};
                        state_next = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_next = IDLE;
                    if (bus.byte_data == 8'hE0 || bus.byte_data == 8'hF0) begin
                        proto_err = 1'b1;
                    end else begin
                        emit      = 1'b1;
                        emit_data = {1'b1, state == EXT_BRK, bus.byte_data};
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            state_next = IDLE;
        end
    end

    // Shift tracking follows every emitted event, including ones the FIFO drops.
    always_comb begin
        shift_l_next = shift_l;
        shift_r_next = shift_r;
        if (emit && !emit_data[8]) begin
            if (emit_data[7:0] == 8'h12) shift_l_next = !emit_data[9];
            if (emit_data[7:0] == 8'h59) shift_r_next = !emit_data[9];
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot that cycle.
    always_comb begin
        do_pop     = bus.rd_en && (bus.fifo_count != '0);
        do_push    = emit && ((bus.fifo_count != FULL_CNT) || do_pop);
        drop       = emit && !do_push;
        rd_next    = rd_ptr + AW'(do_pop);
        count_next = bus.fifo_count + CW'(do_push) - CW'(do_pop);
        if (count_next == '0)
            head_next = '0;
        else if (do_push && (wr_ptr == rd_next))
            head_next = emit_data;
        else
            head_next = mem[rd_next];
    end

    // Event storage; stale contents are harmless because pointers define validity.
    always_ff @(posedge inclock) begin
        if (do_push) mem[wr_ptr] <= emit_data;
    end

    // Sequencer state, timeout counter, FIFO pointers and registered outputs.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            shift_l         <= 1'b0;
            shift_r         <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            bus.event_valid <= 1'b0;
            bus.event_data  <= '0;
            bus.fifo_count  <= '0;
            bus.overflow    <= 1'b0;
            bus.seq_error   <= 1'b0;
            bus.shift_held  <= 1'b0;
        end else begin
            state <= state_next;
            if (bus.byte_valid || state == IDLE || timeout) tmo_cnt <= '0;
            else                                            tmo_cnt <= tmo_cnt + 22'd1;
            shift_l         <= shift_l_next;
            shift_r         <= shift_r_next;
            wr_ptr          <= wr_ptr + AW'(do_push);
            rd_ptr          <= rd_next;
            bus.event_valid <= (count_next != '0);
            bus.event_data  <= head_next;
            bus.fifo_count  <= count_next;
            if (drop)                  bus.overflow <= 1'b1;
            else if (bus.clr_overflow) bus.overflow <= 1'b0;
            bus.seq_error   <= proto_err || timeout;
            bus.shift_held  <= shift_l_next || shift_r_next;
        end
    end
endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb/tb_ps2_scancode_sequencer.sv - scoreboard bench for the PS/2 scancode sequencer
module tb_ps2_scancode_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_scancode_sequencer_if #(.FIFO_DEPTH(4)) bus ();

    ps2_scancode_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
        .inclock(clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT is about to accept is compared with the scoreboard head.
    always @(negedge clk) begin
        if (resetn && bus.rd_en && bus.event_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0h expected=none", bus.event_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (bus.event_data !== e) begin
                    errors++;
                    $display("FAIL pop_data actual=%0h expected=%0h", bus.event_data, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!bus.event_valid) break;
            bus.rd_en = 1'b1;
            @(posedge clk); #1;
            bus.rd_en = 1'b0;
        end
        check("drain_empty", bus.event_valid, 1'b0);
        check("drain_scoreboard", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        bus.byte_valid   = 1'b0;
        bus.byte_data    = '0;
        bus.rd_en        = 1'b0;
        bus.clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", bus.event_valid, 1'b0);
        check("reset_data", bus.event_data, 10'h000);
        check("reset_count", bus.fifo_count, 0);
        check("reset_flags", {bus.overflow, bus.seq_error, bus.shift_held}, 3'b000);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single make, visible one cycle after the strobe.
        send(8'h1C); exp_q.push_back(10'h01C);
        check("make_valid", bus.event_valid, 1'b1);
        check("make_count", bus.fifo_count, 1);
        check("make_head", bus.event_data, 10'h01C);
        drain();

        // Break, extended make, extended break, plus ignored AA/FA.
        send(8'hF0); send(8'h1C); exp_q.push_back(10'h21C);
        send(8'hE0); send(8'h75); exp_q.push_back(10'h175);
        send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back(10'h375);
        send(8'hAA); send(8'hFA);
        check("prefix_count", bus.fifo_count, 3);
        drain();

        // Shift tracking.
        send(8'h12); exp_q.push_back(10'h012);
        check("shift_l", bus.shift_held, 1'b1);
        send(8'h59); exp_q.push_back(10'h059);
        check("shift_lr", bus.shift_held, 1'b1);
        send(8'hF0); send(8'h12); exp_q.push_back(10'h212);
        check("shift_r_only", bus.shift_held, 1'b1);
        send(8'hF0); send(8'h59); exp_q.push_back(10'h259);
        check("shift_none", bus.shift_held, 1'b0);
        drain();
        send(8'hE0); send(8'h12); exp_q.push_back(10'h112);
        check("shift_ext_ignored", bus.shift_held, 1'b0);
        drain();

        // Overflow: fifth make is dropped.
        send(8'h11); send(8'h15); send(8'h16); send(8'h1D); send(8'h22);
        exp_q.push_back(10'h011); exp_q.push_back(10'h015);
        exp_q.push_back(10'h016); exp_q.push_back(10'h01D);
        check("ovf_count", bus.fifo_count, 4);
        check("ovf_flag", bus.overflow, 1'b1);
        check("ovf_head", bus.event_data, 10'h011);
        bus.rd_en = 1'b1;
        send(8'h24); exp_q.push_back(10'h024);
        bus.rd_en = 1'b0;
        check("full_push_pop_count", bus.fifo_count, 4);
        check("full_push_pop_head", bus.event_data, 10'h015);
        check("ovf_sticky", bus.overflow, 1'b1);
        bus.clr_overflow = 1'b1;
        @(posedge clk); #1;
        bus.clr_overflow = 1'b0;
        check("ovf_cleared", bus.overflow, 1'b0);
        drain();

        // Timeout inside an extended prefix.
        send(8'hE0);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            k++;
            if (bus.seq_error) break;
        end
        check("timeout_cycles", k, 100);
        @(posedge clk); #1;
        check("timeout_pulse_width", bus.seq_error, 1'b0);
        send(8'h1C); exp_q.push_back(10'h01C);
        check("after_timeout_head", bus.event_data, 10'h01C);
        drain();

        // Double break prefix is a protocol error with no event.
        send(8'hF0); send(8'hF0);
        check("brk_brk_error", bus.seq_error, 1'b1);
        check("brk_brk_no_event", bus.fifo_count, 0);
        @(posedge clk); #1;
        check("brk_brk_pulse_width", bus.seq_error, 1'b0);

        // Asynchronous reset mid-sequence with events queued (contents discarded).
        send(8'h1C); send(8'h2C); send(8'hE0); send(8'hF0);
        check("pre_reset_count", bus.fifo_count, 2);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_valid", bus.event_valid, 1'b0);
        check("async_reset_data", bus.event_data, 10'h000);
        check("async_reset_count", bus.fifo_count, 0);
        check("async_reset_flags", {bus.overflow, bus.seq_error, bus.shift_held}, 3'b000);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        send(8'h1C); exp_q.push_back(10'h01C);
        check("post_reset_head", bus.event_data, 10'h01C);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
